// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the pipeline MEM stage and
// the data-memory responder.
//   master (core)      : drives mem_read, mem_write, addr, write_data, funct3;
//                        observes busy, read_data, resp_valid, access_fault.
//   slave  (responder) : the mirror image.
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [2:0]  funct3;
  logic        busy;
  logic [31:0] read_data;
  logic        resp_valid;
  logic        access_fault;

  modport master (
    output mem_read, mem_write, addr, write_data, funct3,
    input  busy, read_data, resp_valid, access_fault
  );

  modport slave (
    input  mem_read, mem_write, addr, write_data, funct3,
    output busy, read_data, resp_valid, access_fault
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory for the MEM stage of an RV32IM core.
// Serves byte/halfword/word loads and stores against an internal little-endian
// word array with a fixed access latency, stalling the core through busy and
// returning one response pulse per accepted request.
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : dmem_responder_if.slave
//            in : mem_read, mem_write, addr[31:0], write_data[31:0], funct3[2:0]
//            out: busy (combinational in IDLE), read_data[31:0] (registered),
//                 resp_valid (one-cycle pulse), access_fault (qualifies resp_valid)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned ADDR_W = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          cnt;

  // Request latched at acceptance; held for the whole access.
  logic [ADDR_W-1:0]   addr_p0;
  logic [31:0]         wdata_p0;
  logic [2:0]          funct3_p0;
  logic                write_p0;
  logic                fault_p0;

  logic [31:0]         read_data_q;
  logic                resp_valid_q;
  logic                fault_q;

  logic [31:0]         mem [DEPTH_WORDS];

  logic                commit;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          lane_en;
  logic [31:0]         wdata_al;
  logic                busy_c;

  // Fault decision made at acceptance from the live request.
  function automatic logic check_fault(input logic        is_write,
                                       input logic [2:0]  f3,
                                       input logic [31:0] a);
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    case (f3)
      3'b000: misaligned = 1'b0;
      3'b001: misaligned = a[0];
      3'b010: misaligned = |a[1:0];
      3'b100: bad_f3     = is_write;
      3'b101: begin
        bad_f3     = is_write;
        misaligned = a[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    out_of_range = {2'b00, a[31:2]} >= 32'(DEPTH_WORDS);
    return bad_f3 | misaligned | out_of_range;
  endfunction

  // Byte lanes touched by a (legal) access of the given size.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                           input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across lanes; lane_mask picks the live ones.
  function automatic logic [31:0] store_align(input logic [2:0]  f3,
                                              input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Select and sign/zero-extend the addressed part of a word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'h000000, b};
      3'b101:  return {16'h0000, h};
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign commit   = (state == ACCESS) && (cnt == 4'd0);
  assign idx      = addr_p0[ADDR_W-1:2];
  assign lane_en  = lane_mask(funct3_p0, addr_p0[1:0]);
  assign wdata_al = store_align(funct3_p0, wdata_p0);

  // busy tracks the raw request in IDLE so the core stalls in the same cycle.
  always_comb begin
    busy_c = 1'b0;
    case (state)
      IDLE:    busy_c = bus.mem_read | bus.mem_write;
      ACCESS:  busy_c = 1'b1;
      default: busy_c = 1'b0;
    endcase
  end

  // ---- stage: acceptance -> access countdown -> commit -> response ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      addr_p0      <= '0;
      wdata_p0     <= '0;
      funct3_p0    <= '0;
      write_p0     <= 1'b0;
      fault_p0     <= 1'b0;
      read_data_q  <= '0;
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            addr_p0   <= bus.addr[ADDR_W-1:0];
            wdata_p0  <= bus.write_data;
            funct3_p0 <= bus.funct3;
            // A simultaneous read+write is treated as a store.
            write_p0  <= bus.mem_write;
            fault_p0  <= check_fault(bus.mem_write, bus.funct3, bus.addr);
            cnt       <= 4'(LATENCY - 1);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state        <= RESPOND;
            resp_valid_q <= 1'b1;
            fault_q      <= fault_p0;
            if (!write_p0) begin
              read_data_q <= fault_p0 ? 32'h0000_0000
                                      : load_extend(mem[idx], funct3_p0, addr_p0[1:0]);
            end
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage: store commit into the array (contents never reset) ----
  // An asserted reset forces state to IDLE, so commit cannot fire and a
  // pending store is dropped.
  always_ff @(posedge clk) begin
    if (commit && write_p0 && !fault_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  assign bus.busy         = busy_c;
  assign bus.read_data    = read_data_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.access_fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (DEPTH_WORDS=1024, LATENCY=2). Inputs change on the falling edge and
// outputs are sampled 1 time unit after it.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  // Results of the most recent transaction.
  int          nbusy;
  int          rcyc;
  logic [31:0] rdata;
  logic        flt;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_req();
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.addr       = 32'h0;
    bus.write_data = 32'h0;
    bus.funct3     = 3'b000;
  endtask

  // Drives one request and follows it to its response (bounded at 20 cycles).
  // drop: release the request in cycle 1; hold: keep it through RESPOND.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3,
                            input bit drop, input bit hold);
    nbusy = 0;
    rcyc  = -1;
    rdata = 32'h0;
    flt   = 1'b0;
    @(negedge clk);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.addr       = a;
    bus.write_data = wd;
    bus.funct3     = f3;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.busy) nbusy++;
      if (bus.resp_valid) begin
        rcyc  = c;
        rdata = bus.read_data;
        flt   = bus.access_fault;
        break;
      end
      if (drop && c == 1) clear_req();
      @(negedge clk);
    end
    if (hold) begin
      @(posedge clk);
      #1;
    end
    clear_req();
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.access_fault !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got rv=%b af=%b expected 0 0", bus.resp_valid, bus.access_fault); end
    checks++; if (bus.read_data !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got %h expected 00000000", bus.read_data); end
    checks++; if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b1;
    // SW 0xDEADBEEF @0x10, then reset in cycle 1 of ACCESS.
    @(negedge clk);
    bus.mem_write = 1'b1; bus.addr = 32'h10; bus.write_data = 32'hDEADBEEF; bus.funct3 = 3'b010;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL mid_access_busy: got %b expected 1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.access_fault !== 1'b0 || bus.read_data !== 32'h0) begin
      failures++; $display("FAIL async_reset_outputs: got rv=%b af=%b rd=%h expected 0 0 0",
                           bus.resp_valid, bus.access_fault, bus.read_data); end
    clear_req();
    #1;
    checks++; if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b0);
    checks++; if (rcyc !== LAT + 1 || flt !== 1'b0 || rdata === 32'hDEADBEEF) begin
      failures++; $display("FAIL dropped_store: got cyc=%0d af=%b rd=%h expected cyc=%0d af=0 rd!=deadbeef",
                           rcyc, flt, rdata, LAT + 1); end
  endtask

  task automatic test_word();
    run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 1'b0);
    checks++; if (nbusy !== LAT + 1 || rcyc !== LAT + 1 || flt !== 1'b0) begin
      failures++; $display("FAIL sw_timing: got busy=%0d cyc=%0d af=%b expected %0d %0d 0", nbusy, rcyc, flt, LAT + 1, LAT + 1); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b0);
    checks++; if (nbusy !== LAT + 1 || rcyc !== LAT + 1) begin
      failures++; $display("FAIL lw_timing: got busy=%0d cyc=%0d expected %0d %0d", nbusy, rcyc, LAT + 1, LAT + 1); end
    checks++; if (rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lw_data: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_bytes();
    run_access(1'b0, 1'b1, 32'h13, 32'h0000007F, 3'b000, 1'b0, 1'b0);
    run_access(1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 1'b0, 1'b0);
    checks++; if (rdata !== 32'h0000007F) begin
      failures++; $display("FAIL lb_13: got %h expected 0000007f", rdata); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b0);
    checks++; if (rdata !== 32'h7FADBEEF) begin
      failures++; $display("FAIL lw_after_sb: got %h expected 7fadbeef", rdata); end
    run_access(1'b1, 1'b0, 32'h12, 32'h0, 3'b000, 1'b0, 1'b0);
    checks++; if (rdata !== 32'hFFFFFFAD) begin
      failures++; $display("FAIL lb_12: got %h expected ffffffad", rdata); end
    run_access(1'b1, 1'b0, 32'h12, 32'h0, 3'b100, 1'b0, 1'b0);
    checks++; if (rdata !== 32'h000000AD) begin
      failures++; $display("FAIL lbu_12: got %h expected 000000ad", rdata); end
  endtask

  task automatic test_halfwords();
    run_access(1'b0, 1'b1, 32'h22, 32'h00008001, 3'b001, 1'b0, 1'b0);
    run_access(1'b1, 1'b0, 32'h22, 32'h0, 3'b001, 1'b0, 1'b0);
    checks++; if (rdata !== 32'hFFFF8001) begin
      failures++; $display("FAIL lh_22: got %h expected ffff8001", rdata); end
    run_access(1'b1, 1'b0, 32'h22, 32'h0, 3'b101, 1'b0, 1'b0);
    checks++; if (rdata !== 32'h00008001) begin
      failures++; $display("FAIL lhu_22: got %h expected 00008001", rdata); end
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 1'b0);
    checks++; if (rdata[31:16] !== 16'h8001) begin
      failures++; $display("FAIL lw_20_upper: got %h expected 8001xxxx", rdata); end
  endtask

  task automatic test_faults();
    run_access(1'b1, 1'b0, 32'h21, 32'h0, 3'b001, 1'b0, 1'b0);
    checks++; if (flt !== 1'b1 || rdata !== 32'h0 || nbusy !== LAT + 1 || rcyc !== LAT + 1) begin
      failures++; $display("FAIL lh_misaligned: got af=%b rd=%h busy=%0d cyc=%0d expected 1 0 %0d %0d",
                           flt, rdata, nbusy, rcyc, LAT + 1, LAT + 1); end
    run_access(1'b0, 1'b1, 32'h12, 32'h11111111, 3'b010, 1'b0, 1'b0);
    checks++; if (flt !== 1'b1 || nbusy !== LAT + 1) begin
      failures++; $display("FAIL sw_misaligned: got af=%b busy=%0d expected 1 %0d", flt, nbusy, LAT + 1); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b0);
    checks++; if (rdata !== 32'h7FADBEEF || flt !== 1'b0) begin
      failures++; $display("FAIL no_write_on_fault: got %h af=%b expected 7fadbeef 0", rdata, flt); end
    run_access(1'b1, 1'b0, DEPTH * 4, 32'h0, 3'b010, 1'b0, 1'b0);
    checks++; if (flt !== 1'b1 || rdata !== 32'h0) begin
      failures++; $display("FAIL lw_out_of_range: got af=%b rd=%h expected 1 0", flt, rdata); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 1'b0, 1'b0);
    checks++; if (flt !== 1'b1 || rdata !== 32'h0) begin
      failures++; $display("FAIL load_f3_011: got af=%b rd=%h expected 1 0", flt, rdata); end
    run_access(1'b0, 1'b1, 32'h10, 32'h0, 3'b100, 1'b0, 1'b0);
    checks++; if (flt !== 1'b1) begin
      failures++; $display("FAIL store_f3_100: got af=%b expected 1", flt); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 1'b0);
    checks++; if (rdata !== 32'h7FADBEEF) begin
      failures++; $display("FAIL no_write_store_f3: got %h expected 7fadbeef", rdata); end
  endtask

  task automatic test_read_hold();
    // Previous load returned 0x7FADBEEF; a store response must not disturb it.
    run_access(1'b0, 1'b1, 32'h50, 32'h00000055, 3'b000, 1'b0, 1'b0);
    checks++; if (rdata !== 32'h7FADBEEF || flt !== 1'b0) begin
      failures++; $display("FAIL rdata_hold_store: got %h af=%b expected 7fadbeef 0", rdata, flt); end
    // Request withdrawn mid-ACCESS still completes.
    run_access(1'b1, 1'b0, 32'h50, 32'h0, 3'b100, 1'b1, 1'b0);
    checks++; if (rdata !== 32'h00000055 || rcyc !== LAT + 1) begin
      failures++; $display("FAIL drop_mid_access: got %h cyc=%0d expected 00000055 %0d", rdata, rcyc, LAT + 1); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b1, 32'h40, 32'h12345678, 3'b010, 1'b0, 1'b0);
    checks++; if (flt !== 1'b0 || rcyc !== LAT + 1 || rdata !== 32'h00000055) begin
      failures++; $display("FAIL rw_both_store: got af=%b cyc=%0d rd=%h expected 0 %0d 00000055", flt, rcyc, rdata, LAT + 1); end
    // Issued in the cycle right after RESPOND: must be accepted at once.
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 1'b0, 1'b1);
    checks++; if (rdata !== 32'h12345678 || rcyc !== LAT + 1 || nbusy !== LAT + 1) begin
      failures++; $display("FAIL b2b_lw_40: got %h cyc=%0d busy=%0d expected 12345678 %0d %0d",
                           rdata, rcyc, nbusy, LAT + 1, LAT + 1); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
        failures++; $display("FAIL held_not_reaccepted[%0d]: got busy=%b rv=%b expected 0 0", i, bus.busy, bus.resp_valid); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clear_req();
    test_reset();
    test_word();
    test_bytes();
    test_halfwords();
    test_faults();
    test_read_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves the MEM stage of the RV32IM pipeline. It accepts the core's load and store requests: `mem_read`/`mem_write`, address, store data and `funct3`. It performs byte, halfword and word accesses to an internal little-endian word array with a fixed, parameterised access latency. While an access is in flight it asserts `busy` so the pipeline stalls, then returns load data and a fault flag for one cycle.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 2: access cycles between acceptance and response; ≥ 1, ≤ 15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mem_read` input 1: load request; held stable by the core until `busy` drops.
- `mem_write` input 1: store request; held stable by the core until `busy` drops.
- `addr` input 32: byte address.
- `write_data` input 32: store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- `funct3` input 3: access size and sign, using the RV32 load/store encoding.
- `busy` output 1: stall request to the core; combinational in IDLE.
- `read_data` output 32: extended load result; registered.
- `resp_valid` output 1: one-cycle pulse, response present this cycle.
- `access_fault` output 1: qualifies `resp_valid`; the access was rejected.

## Operation
- FSM states:
  - IDLE.
  - ACCESS (counter `cnt`, 4 bits).
  - RESPOND.
- IDLE:
  - `busy` = `mem_read | mem_write`.
  - On an edge with a request present, latch `addr`, `write_data`, `funct3` and the op into internal registers.
  - Load `cnt` = LATENCY-1 and go to ACCESS.
  - If both `mem_read` and `mem_write` are high, the write wins and the read is ignored.
- ACCESS:
  - `busy` = 1.
  - If `cnt` ≠ 0, decrement `cnt`.
  - If `cnt` = 0, commit the access on this edge and go to RESPOND.
  - Commit for a store: byte-lane write into the array.
  - Commit for a load: the extended result is registered into `read_data`.
- RESPOND:
  - `busy` = 0 and `resp_valid` = 1 for exactly one cycle, then IDLE unconditionally.
  - Requests present during RESPOND are not accepted; the core advances at the edge ending RESPOND.
- Size decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other `funct3` is a fault.
- Lanes (little-endian):
  - Byte: lane = `addr[1:0]`.
  - Half: lanes {`addr[1]`*2+1, `addr[1]`*2}.
  - Word: all four lanes.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Faults, decided at acceptance:
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - Illegal `funct3`.
  - Word index `addr[31:2]` ≥ DEPTH_WORDS.
- Fault handling:
  - Same timing as a normal access.
  - No array write.
  - `read_data` = 0 on a faulting load.
  - `access_fault` = 1 alongside `resp_valid`.
- `read_data` updates only on load responses; it holds its value across stores and idle cycles.
- Word index = `addr[2 +: log2(DEPTH_WORDS)]`; index bits above that range are covered by the out-of-range check.

## Timing
- Reset (`reset`=0), immediate and asynchronous:
  - State = IDLE, `cnt` = 0.
  - `read_data` = 0, `resp_valid` = 0, `access_fault` = 0, all latched request registers = 0.
  - `busy` follows its combinational IDLE rule.
  - Array contents are not initialised or cleared.
- Latency:
  - Request seen in cycle 0 (IDLE).
  - ACCESS occupies cycles 1..LATENCY.
  - RESPOND is cycle LATENCY+1.
  - `busy` is high in cycles 0..LATENCY (LATENCY+1 cycles).
- Store commit happens on the edge ending cycle LATENCY.
- Reset asserted before the commit edge drops the pending store; the array is unchanged.
- Back-to-back accesses: minimum spacing is LATENCY+2 cycles (a request in the cycle after RESPOND is accepted immediately).
- Request deasserted by the core mid-ACCESS is ignored; the latched request completes.

## Test plan
- Reset with `reset`=0 mid-ACCESS of SW 0xDEADBEEF @0x10, then LW @0x10 → SW commit dropped; LW `read_data` ≠ 0xDEADBEEF (uninitialised array); `resp_valid`/`access_fault`/`read_data` = 0 during reset.
- LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 → `busy` high 3 cycles each, `resp_valid` in cycle 3, `read_data` = 0xDEADBEEF.
- Byte lanes: after the word above, SB 0x7F @0x13, then LB @0x13 → 0x0000007F; LW @0x10 → 0x7FADBEEF; LB @0x12 → 0xFFFFFFAD; LBU @0x12 → 0x000000AD.
- Halfwords: SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001; LHU @0x22 → 0x00008001; LW @0x20 → 0x8001xxxx (upper half written, lower untouched).
- Faults: LH @0x21, SW @0x12 and LW @(DEPTH_WORDS*4) → `access_fault`=1 with `resp_valid`, LATENCY+1 busy cycles, no array change, load `read_data` = 0; `funct3`=011 → fault.
- Simultaneous `mem_read`=`mem_write`=1 SW 0x12345678 @0x40 → treated as a store; a following LW @0x40 → 0x12345678; a request held through RESPOND → not re-accepted.
